riscv_trace_buf: RTL and testbench

RISCV_TRACE_BUF -- requirements
Module: riscv_trace_buf

---
 rtl/riscv_trace_pkg.sv | 38 +++
 rtl/trace_fifo_2w1r.sv | 46 ++++
 rtl/riscv_trace_buf.sv | 111 +++++++++++
 tb/tb_riscv_trace_buf.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_trace_pkg.sv
// Shared types for the RISC-V trace buffer: record kinds, capture modes
// and the packed trace record layout.
package riscv_trace_pkg;

    localparam int TR_DATA_W = 32;
    localparam int TR_ADDR_W = 9;
    localparam int TR_CNT_W  = 16;

    typedef enum logic [1:0] {
        K_REG   = 2'b00,
        K_STORE = 2'b01,
        K_LOAD  = 2'b10
    } kind_t;

    typedef enum logic [1:0] {
        M_REG  = 2'b00,
        M_MEM  = 2'b01,
        M_BOTH = 2'b10,
        M_NONE = 2'b11
    } mode_t;

    // Field order matches the flat record stored in the FIFO.
    typedef struct packed {
        kind_t                  kind;
        logic [TR_ADDR_W-1:0]   index;
        logic [TR_DATA_W-1:0]   data;
        logic [TR_CNT_W-1:0]    tstamp;
    } trace_rec_t;

    function automatic logic takes_reg(mode_t m);
        return (m == M_REG) || (m == M_BOTH);
    endfunction

    function automatic logic takes_mem(mode_t m);
        return (m == M_MEM) || (m == M_BOTH);
    endfunction

endpackage

// File: rtl/trace_fifo_2w1r.sv
// Trace record storage: two write ports (in order) and one read port.
// Occupancy and pointers live here; callers never overfill it.
module trace_fifo_2w1r #(
    parameter int DEPTH = 16,
    parameter int W     = 59
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    we0,
    input  logic [W-1:0]            wd0,
    input  logic                    we1,
    input  logic [W-1:0]            wd1,
    input  logic                    pop,
    output logic [W-1:0]            head,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    // we1 is only raised together with we0, so it lands in the next slot.
    always_ff @(posedge clk) begin
        if (we0) mem[wptr] <= wd0;
        if (we1) mem[wptr + PW'(1)] <= wd1;
    end

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + PW'(we0) + PW'(we1);
            rptr  <= rptr + PW'(pop);
            count <= count + CW'(we0) + CW'(we1) - CW'(pop);
        end
    end

    assign head = mem[rptr];

endmodule

// File: rtl/riscv_trace_buf.sv
// Captures register writeback and load/store events into a small FIFO
// with timestamps and a saturating dropped-record counter.
module riscv_trace_buf
    import riscv_trace_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [1:0]              mode,
    input  logic                    clr,
    input  logic                    reg_write_sig,
    input  logic [4:0]              reg_num,
    input  logic [DATA_W-1:0]       reg_data,
    input  logic                    wr,
    input  logic                    rd,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic [DATA_W-1:0]       rd_data,
    output logic                    tr_valid,
    input  logic                    tr_ready,
    output logic [1:0]              tr_kind,
    output logic [ADDR_W-1:0]       tr_index,
    output logic [DATA_W-1:0]       tr_data,
    output logic [CNT_W-1:0]        tr_time,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
    output logic [CNT_W-1:0]        ovf_cnt
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int REC_W = 2 + ADDR_W + DATA_W + CNT_W;

    logic [CNT_W-1:0] tick;
    logic             reg_ev;
    logic             mem_ev;
    logic             pop;
    logic             we0;
    logic             we1;
    kind_t            mem_kind;
    logic [REC_W-1:0] mem_rec;
    logic [REC_W-1:0] reg_rec;
    logic [REC_W-1:0] wd0;
    logic [REC_W-1:0] head;
    logic [1:0]       n_ev;
    logic [1:0]       n_push;
    logic [1:0]       drop;
    logic [CW-1:0]    free;
    logic [CNT_W:0]   ovf_sum;

    assign reg_ev = en && reg_write_sig && (reg_num != 5'd0)
                    && takes_reg(mode_t'(mode));
    assign mem_ev = en && (wr || rd) && takes_mem(mode_t'(mode));

    assign mem_kind = wr ? K_STORE : K_LOAD;
    assign mem_rec  = {mem_kind, addr, (wr ? wr_data : rd_data), tick};
    assign reg_rec  = {K_REG, ADDR_W'(reg_num), reg_data, tick};

    // MEM goes first, so when only one slot is free the MEM record wins.
    assign pop    = tr_valid && tr_ready;
    assign free   = CW'(DEPTH) - count + CW'(pop);
    assign n_ev   = {1'b0, mem_ev} + {1'b0, reg_ev};
    assign n_push = (CW'(n_ev) <= free) ? n_ev : free[1:0];
    assign drop   = n_ev - n_push;
    assign we0    = !clr && (n_push != 2'd0);
    assign we1    = !clr && (n_push == 2'd2);
    assign wd0    = mem_ev ? mem_rec : reg_rec;
    assign ovf_sum = {1'b0, ovf_cnt} + (CNT_W+1)'(drop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            tick    <= '0;
            ovf_cnt <= '0;
        end else begin
            tick <= tick + CNT_W'(1);
            if (clr)
                ovf_cnt <= '0;
            else if (ovf_sum[CNT_W])
                ovf_cnt <= '1;
            else
                ovf_cnt <= ovf_sum[CNT_W-1:0];
        end
    end

    trace_fifo_2w1r #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .we0   (we0),
        .wd0   (wd0),
        .we1   (we1),
        .wd1   (reg_rec),
        .pop   (pop && !clr),
        .head  (head),
        .count (count)
    );

    assign empty    = (count == CW'(0));
    assign full     = (count == CW'(DEPTH));
    assign tr_valid = !empty;
    assign {tr_kind, tr_index, tr_data, tr_time} = tr_valid ? head : '0;

endmodule

// File: tb/tb_riscv_trace_buf.sv
// Directed bench for riscv_trace_buf with a record scoreboard and a
// small occupancy/overflow model.
module tb_riscv_trace_buf;
    import riscv_trace_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        clr = 1'b0;
    logic        reg_write_sig = 1'b0;
    logic [4:0]  reg_num = '0;
    logic [31:0] reg_data = '0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [8:0]  addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data = '0;
    logic        tr_ready = 1'b0;
    logic        tr_valid;
    logic [1:0]  tr_kind;
    logic [8:0]  tr_index;
    logic [31:0] tr_data;
    logic [15:0] tr_time;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic [15:0] ovf_cnt;

    int checks = 0;
    int errors = 0;
    trace_rec_t sb[$];
    int mcnt = 0;
    int movf = 0;
    logic [15:0] tm = '0;

    always #5 clk = ~clk;

    riscv_trace_buf dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .mode          (mode),
        .clr           (clr),
        .reg_write_sig (reg_write_sig),
        .reg_num       (reg_num),
        .reg_data      (reg_data),
        .wr            (wr),
        .rd            (rd),
        .addr          (addr),
        .wr_data       (wr_data),
        .rd_data       (rd_data),
        .tr_valid      (tr_valid),
        .tr_ready      (tr_ready),
        .tr_kind       (tr_kind),
        .tr_index      (tr_index),
        .tr_data       (tr_data),
        .tr_time       (tr_time),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .ovf_cnt       (ovf_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_count"}, count, mcnt);
        chk({tag, "_ovf"}, ovf_cnt, movf);
        chk({tag, "_valid"}, tr_valid, mcnt != 0);
        chk({tag, "_full"}, full, mcnt == 16);
        chk({tag, "_empty"}, empty, mcnt == 0);
        if (mcnt == 0)
            chk({tag, "_zero"}, {tr_kind, tr_index, tr_data, tr_time}, 0);
    endtask

    // One clock cycle: drive inputs, score any pop, update model, check.
    task automatic cyc(input bit rdy, input logic [1:0] md, input bit e,
                       input bit c, input bit w, input bit r,
                       input logic [8:0] a, input logic [31:0] wd,
                       input logic [31:0] rdd, input bit rg,
                       input logic [4:0] rn, input logic [31:0] rgd);
        bit mev;
        bit rev;
        int fr;
        trace_rec_t rec;
        tr_ready = rdy; mode = md; en = e; clr = c;
        wr = w; rd = r; addr = a; wr_data = wd; rd_data = rdd;
        reg_write_sig = rg; reg_num = rn; reg_data = rgd;
        mev = e && (w || r) && (md == 2'b01 || md == 2'b10);
        rev = e && rg && (rn != 5'd0) && (md == 2'b00 || md == 2'b10);
        if (c) begin
            sb.delete();
            mcnt = 0;
            movf = 0;
        end else begin
            if (mcnt > 0 && rdy) begin
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    rec = sb.pop_front();
                    chk("pop_kind", tr_kind, rec.kind);
                    chk("pop_index", tr_index, rec.index);
                    chk("pop_data", tr_data, rec.data);
                    chk("pop_time", tr_time, rec.tstamp);
                end
                mcnt--;
            end
            fr = 16 - mcnt;
            if (mev) begin
                if (fr > 0) begin
                    rec.kind = w ? K_STORE : K_LOAD;
                    rec.index = a;
                    rec.data = w ? wd : rdd;
                    rec.tstamp = tm;
                    sb.push_back(rec);
                    mcnt++;
                    fr--;
                end else movf++;
            end
            if (rev) begin
                if (fr > 0) begin
                    rec.kind = K_REG;
                    rec.index = {4'b0, rn};
                    rec.data = rgd;
                    rec.tstamp = tm;
                    sb.push_back(rec);
                    mcnt++;
                end else movf++;
            end
            if (movf > 65535) movf = 65535;
        end
        @(posedge clk);
        #1;
        tm++;
        chk_status("cyc");
    endtask

    task automatic idle(input bit rdy);
        cyc(rdy, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        tm = '0;
        chk_status("reset");
        chk("reset_fields", {tr_kind, tr_index, tr_data, tr_time}, 0);

        repeat (5) idle(1'b0);
        cyc(1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 9'h040, 32'h0,
            32'hDEADBEEF, 1'b1, 5'd7, 32'hDEADBEEF);
        chk("dual_count", count, 2);
        chk("dual_kind", tr_kind, K_LOAD);
        chk("dual_index", tr_index, 9'h040);
        chk("dual_data", tr_data, 32'hDEADBEEF);
        chk("dual_time", tr_time, 16'd5);
        idle(1'b1);
        chk("second_kind", tr_kind, K_REG);
        chk("second_index", tr_index, 9'd7);
        chk("second_time", tr_time, 16'd5);
        idle(1'b1);

        cyc(1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0,
            1'b1, 5'd0, 32'h1234);
        chk("x0_count", count, 0);
        cyc(1'b0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 9'h11, 32'h1, '0,
            1'b1, 5'd4, 32'h2);
        cyc(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 9'h12, '0, 32'h3,
            1'b1, 5'd5, 32'h4);
        cyc(1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 9'h13, 32'h5, '0,
            1'b0, '0, '0);
        cyc(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0,
            1'b1, 5'd6, 32'h6);
        chk("filtered_count", count, 0);

        cyc(1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 9'h1FF, 32'hA5A5A5A5,
            32'h5A5A5A5A, 1'b0, '0, '0);
        chk("wrrd_count", count, 1);
        chk("wrrd_kind", tr_kind, K_STORE);
        chk("wrrd_data", tr_data, 32'hA5A5A5A5);
        idle(1'b1);

        for (int i = 0; i < 15; i++)
            cyc(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0,
                1'b1, 5'(i + 1), $urandom);
        cyc(1'b0, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 9'h0AA, 32'h11, '0,
            1'b1, 5'd3, 32'h22);
        chk("fill_full", full, 1'b1);
        chk("fill_ovf", ovf_cnt, 16'd1);
        cyc(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 9'h0BB, '0, 32'h33,
            1'b1, 5'd9, 32'h44);
        chk("popfull_ovf", ovf_cnt, 16'd2);
        cyc(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 9'h0CC, '0, 32'h55,
            1'b0, '0, '0);
        chk("ovf3", ovf_cnt, 16'd3);
        cyc(1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 9'h0DD, 32'h66, '0,
            1'b1, 5'd2, 32'h77);
        chk("clr_count", count, 0);
        chk("clr_ovf", ovf_cnt, 0);
        chk("clr_valid", tr_valid, 1'b0);
        cyc(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0,
            1'b1, 5'd8, 32'h88);
        chk("postclr_time", tr_time, tm - 16'd1);
        idle(1'b1);

        for (int i = 0; i < 24; i++) begin
            logic [3:0] rr;
            rr = 4'($urandom);
            cyc(rr[3], 2'b10, 1'b1, 1'b0, rr[0], rr[1], 9'($urandom),
                $urandom, $urandom, rr[2], 5'($urandom), $urandom);
        end
        for (int i = 0; i < 20 && mcnt > 0; i++) idle(1'b1);
        chk("drain_empty", empty, 1'b1);

        for (int i = 0; i < 8; i++)
            cyc(1'b0, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 9'(i), 32'(i), '0,
                1'b1, 5'd1, 32'(i));
        for (int i = 0; i < 32769; i++)
            cyc(1'b0, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, '0, '0, '0,
                1'b1, 5'd1, '0);
        chk("ovf_sat", ovf_cnt, 16'hFFFF);

        cyc(1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0);
        reset = 1'b0;
        tr_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        mcnt = 0;
        movf = 0;
        tm = '0;
        chk_status("midreset");
        cyc(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0,
            1'b1, 5'd31, 32'hCAFE);
        chk("midreset_time", tr_time, 16'd0);
        idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
